// File: rtl/vcache_profiler_pkg.sv
// ---------------------------------------------------------------------------
// vcache_profiler_pkg
//   Shared definitions for the vcache profiler blocks.
//   - print_stat_state_e : announce sequencer states of vcache_print_stat_gen
//   - vcache_global_ctr_width_gp : width of the free-running global cycle
//     counter that every profiler instance timestamps against
// ---------------------------------------------------------------------------
package vcache_profiler_pkg;

    localparam int vcache_global_ctr_width_gp = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DRAIN = 2'd1,
        ANNOUNCE   = 2'd2
    } print_stat_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// ---------------------------------------------------------------------------
// bsg_fifo_1r1w_small
//   Small one-read/one-write FIFO used as the stat-print tag queue.
//   Ports:
//     clk_i, reset_i      : clock, synchronous active-high reset
//     v_i, data_i         : enqueue request and data
//     ready_o             : not full (registered, forced low during reset)
//     v_o, data_o         : head valid and head data
//     yumi_i              : dequeue the head this cycle
//   ready_o depends only on registered state, so an enqueue and a dequeue
//   in the same cycle never bypass each other: a full queue accepts again
//   only the cycle after a pop.
// ---------------------------------------------------------------------------
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

    logic [width_p-1:0]      mem_reg [els_p];
    logic [ptr_width_lp-1:0] wptr_reg, wptr_next;
    logic [ptr_width_lp-1:0] rptr_reg, rptr_next;
    logic                    full_reg, full_next;
    logic                    empty_reg, empty_next;
    logic                    enq, deq;
    logic [els_p-1:0]        wen;

    assign ready_o = ~full_reg & ~reset_i;
    assign v_o     = ~empty_reg;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & ~empty_reg;

    // Head is read combinationally so the tag is present in the pop cycle.
    assign data_o  = mem_reg[rptr_reg];

    for (genvar gi = 0; gi < els_p; gi++) begin : g_wen
        assign wen[gi] = enq & (wptr_reg == ptr_width_lp'(gi));
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < els_p; i++) begin
            if (wen[i]) begin
                mem_reg[i] <= data_i;
            end
        end
    end

    // Full/empty are decided from the pointer that will result, so the
    // flags are ready as registers one cycle after the causing operation.
    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        full_next  = full_reg;
        empty_next = empty_reg;
        if (enq) begin
            wptr_next = (wptr_reg == last_ptr_lp) ? '0 : wptr_reg + 1'b1;
        end
        if (deq) begin
            rptr_next = (rptr_reg == last_ptr_lp) ? '0 : rptr_reg + 1'b1;
        end
        if (enq && !deq) begin
            empty_next = 1'b0;
            full_next  = (wptr_next == rptr_reg);
        end else if (deq && !enq) begin
            full_next  = 1'b0;
            empty_next = (rptr_next == wptr_reg);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
        end
    end

endmodule

// File: rtl/vcache_print_stat_gen.sv
// ---------------------------------------------------------------------------
// vcache_print_stat_gen
//   Produces the stat-print event stream for the vcache profilers: a
//   free-running global cycle counter, a one-cycle print pulse and its tag.
//   Requests are queued and, when drain tracking is built in, announced only
//   once the vcache has no outstanding requests (or a drain timeout expires).
//
//   Build option: define VCACHE_PRINT_STAT_DRAIN_EN to include the inflight
//   counter, the WAIT_DRAIN state and the drain timeout. Without it IDLE goes
//   straight to ANNOUNCE, req/resp are ignored and drain_timeout_o is 0.
//
//   Ports:
//     clk_i, reset_i                : clock, synchronous active-high reset
//     stat_v_i, stat_tag_i          : stat-print request and its tag
//     stat_ready_o                  : tag queue not full
//     req_v_i, req_ready_i          : vcache input handshake (monitor only)
//     resp_v_i, resp_yumi_i         : vcache output handshake (monitor only)
//     global_ctr_o                  : free-running cycle counter
//     print_stat_v_o                : one-cycle announce pulse
//     print_stat_tag_o              : announced tag, 0 when not announcing
//     drain_timeout_o               : sticky, an announce was forced
// ---------------------------------------------------------------------------
module vcache_print_stat_gen
    import vcache_profiler_pkg::*;
#(
    parameter int data_width_p    = 32,
    parameter int els_p           = 4,
    parameter int max_inflight_p  = 8,
    parameter int drain_timeout_p = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  stat_v_i,
    input  logic [data_width_p-1:0]               stat_tag_i,
    output logic                                  stat_ready_o,
    input  logic                                  req_v_i,
    input  logic                                  req_ready_i,
    input  logic                                  resp_v_i,
    input  logic                                  resp_yumi_i,
    output logic [vcache_global_ctr_width_gp-1:0] global_ctr_o,
    output logic                                  print_stat_v_o,
    output logic [data_width_p-1:0]               print_stat_tag_o,
    output logic                                  drain_timeout_o
);

    print_stat_state_e state_reg, state_next;

    logic                                  fifo_v;
    logic [data_width_p-1:0]               fifo_data;
    logic                                  fifo_yumi;
    logic                                  announce;
    logic                                  drain_force;
    logic [vcache_global_ctr_width_gp-1:0] global_ctr_reg;

    // ------------------------------------------------------------------
    // Tag queue
    // ------------------------------------------------------------------
    bsg_fifo_1r1w_small #(
        .width_p (data_width_p),
        .els_p   (els_p)
    ) tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (stat_v_i),
        .ready_o (stat_ready_o),
        .data_i  (stat_tag_i),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_yumi)
    );

    // ------------------------------------------------------------------
    // Global cycle counter (wraps naturally at 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            global_ctr_reg <= '0;
        end else begin
            global_ctr_reg <= global_ctr_reg + 1'b1;
        end
    end

    assign global_ctr_o = global_ctr_reg;

`ifdef VCACHE_PRINT_STAT_DRAIN_EN
    // ------------------------------------------------------------------
    // Outstanding vcache request tracking and drain timeout
    // ------------------------------------------------------------------
    localparam int inflight_width_lp = $clog2(max_inflight_p + 1);
    localparam int timer_width_lp    = (drain_timeout_p > 1) ? $clog2(drain_timeout_p) : 1;
    localparam logic [inflight_width_lp-1:0] inflight_max_lp = inflight_width_lp'(max_inflight_p);
    localparam logic [timer_width_lp-1:0]    timer_last_lp   = timer_width_lp'(drain_timeout_p - 1);

    logic                         inflight_inc, inflight_dec;
    logic [inflight_width_lp-1:0] inflight_reg, inflight_next;
    logic [timer_width_lp-1:0]    timer_reg;
    logic                         drain_timeout_reg;

    assign inflight_inc = req_v_i & req_ready_i;
    assign inflight_dec = resp_v_i & resp_yumi_i;

    // Over/underflow would mean the monitored handshakes are inconsistent;
    // the count holds rather than wrapping so the drain check stays sane.
    always_comb begin
        inflight_next = inflight_reg;
        if (inflight_inc && !inflight_dec && inflight_reg != inflight_max_lp) begin
            inflight_next = inflight_reg + 1'b1;
        end else if (inflight_dec && !inflight_inc && inflight_reg != '0) begin
            inflight_next = inflight_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(inflight_inc && !inflight_dec && inflight_reg == inflight_max_lp));
            assert (!(inflight_dec && !inflight_inc && inflight_reg == '0));
        end
    end
`endif

    // Held at zero outside WAIT_DRAIN, so it starts from 0 on every entry.
    always_ff @(posedge clk_i) begin
        if (reset_i || state_reg != WAIT_DRAIN) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drain_timeout_reg <= 1'b0;
        end else if (drain_force) begin
            drain_timeout_reg <= 1'b1;
        end
    end

    assign drain_timeout_o = drain_timeout_reg;
`else
    logic unused_monitor;
    assign unused_monitor = ^{req_v_i, req_ready_i, resp_v_i, resp_yumi_i, drain_force,
                              (max_inflight_p > 0), (drain_timeout_p > 0)};
    assign drain_timeout_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Announce sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Announce sequencer: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        drain_force = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fifo_v) begin
`ifdef VCACHE_PRINT_STAT_DRAIN_EN
                    state_next = WAIT_DRAIN;
`else
                    state_next = ANNOUNCE;
`endif
                end
            end
            WAIT_DRAIN: begin
`ifdef VCACHE_PRINT_STAT_DRAIN_EN
                if (inflight_reg == '0) begin
                    state_next = ANNOUNCE;
                end else if (timer_reg == timer_last_lp) begin
                    state_next  = ANNOUNCE;
                    drain_force = 1'b1;
                end
`else
                state_next = IDLE;
`endif
            end
            ANNOUNCE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Announce sequencer: outputs. Gated by reset so a reset landing on an
    // ANNOUNCE cycle produces no pulse and pops nothing.
    // ------------------------------------------------------------------
    always_comb begin
        announce         = (state_reg == ANNOUNCE) & ~reset_i;
        print_stat_v_o   = announce;
        print_stat_tag_o = announce ? fifo_data : '0;
        fifo_yumi        = announce;
    end

endmodule

// File: tb/tb_vcache_print_stat_gen.sv
// ---------------------------------------------------------------------------
// tb_vcache_print_stat_gen
//   Directed bench for vcache_print_stat_gen (data_width_p=8, els_p=4,
//   max_inflight_p=8, drain_timeout_p=16). Inputs change and outputs are
//   sampled 1 time unit after the rising edge. Expected announce timing
//   follows the build: with VCACHE_PRINT_STAT_DRAIN_EN the pulse lands
//   3 cycles after accept and repeats every 3 cycles, otherwise 2 and 2.
// ---------------------------------------------------------------------------
module tb_vcache_print_stat_gen;

`ifdef VCACHE_PRINT_STAT_DRAIN_EN
    localparam int          announce_lat_lp = 3;
    localparam int          announce_gap_lp = 3;
    localparam int          t2_cycles_lp    = 20;
    localparam logic [19:0] t2_ready_lp     = 20'b11111111110010011111;
`else
    localparam int          announce_lat_lp = 2;
    localparam int          announce_gap_lp = 2;
    localparam int          t2_cycles_lp    = 14;
    localparam logic [19:0] t2_ready_lp     = 20'b00000011111110111111;
`endif

    logic        clk_i;
    logic        reset_i;
    logic        stat_v_i;
    logic [7:0]  stat_tag_i;
    logic        stat_ready_o;
    logic        req_v_i;
    logic        req_ready_i;
    logic        resp_v_i;
    logic        resp_yumi_i;
    logic [31:0] global_ctr_o;
    logic        print_stat_v_o;
    logic [7:0]  print_stat_tag_o;
    logic        drain_timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    vcache_print_stat_gen #(
        .data_width_p    (8),
        .els_p           (4),
        .max_inflight_p  (8),
        .drain_timeout_p (16)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .stat_v_i         (stat_v_i),
        .stat_tag_i       (stat_tag_i),
        .stat_ready_o     (stat_ready_o),
        .req_v_i          (req_v_i),
        .req_ready_i      (req_ready_i),
        .resp_v_i         (resp_v_i),
        .resp_yumi_i      (resp_yumi_i),
        .global_ctr_o     (global_ctr_o),
        .print_stat_v_o   (print_stat_v_o),
        .print_stat_tag_o (print_stat_tag_o),
        .drain_timeout_o  (drain_timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [19:0] ready_tbl;
        int          acc;
        int          k;
        logic        exp_pulse;

        reset_i     = 1'b1;
        stat_v_i    = 1'b0;
        stat_tag_i  = 8'h00;
        req_v_i     = 1'b0;
        req_ready_i = 1'b0;
        resp_v_i    = 1'b0;
        resp_yumi_i = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_ready", 32'(stat_ready_o), 32'd0);
        check_val("rst_v", 32'(print_stat_v_o), 32'd0);
        check_val("rst_tag", 32'(print_stat_tag_o), 32'd0);
        check_val("rst_ctr", global_ctr_o, 32'd0);
        check_val("rst_to", 32'(drain_timeout_o), 32'd0);
        reset_i = 1'b0;
        #1;
        check_val("rel_ready", 32'(stat_ready_o), 32'd1);
        check_val("rel_ctr", global_ctr_o, 32'd0);
        $display("reset released, ctr=%0d ready=%0d", global_ctr_o, stat_ready_o);

        // ---------------- T1: single request, empty pipeline ----------------
        stat_v_i   = 1'b1;
        stat_tag_i = 8'hA5;
        for (int i = 1; i <= announce_lat_lp + 1; i++) begin
            tick();
            stat_v_i = 1'b0;
            check_val("t1_v", 32'(print_stat_v_o), 32'(i == announce_lat_lp));
            check_val("t1_tag", 32'(print_stat_tag_o), (i == announce_lat_lp) ? 32'hA5 : 32'd0);
            if (i == announce_lat_lp) begin
                check_val("t1_ctr", global_ctr_o, 32'(announce_lat_lp));
            end
            check_val("t1_to", 32'(drain_timeout_o), 32'd0);
        end
        $display("T1 single request tag a5 done");
        tick();

        // ---------------- T2: streaming 6 tags into a 4-deep queue ----------------
        ready_tbl = t2_ready_lp;
        acc = 0;
        for (int i = 0; i < t2_cycles_lp; i++) begin
            stat_v_i   = (acc < 6);
            stat_tag_i = 8'(8'h11 + acc);
            k = (i - announce_lat_lp) / announce_gap_lp;
            exp_pulse = (i >= announce_lat_lp) && (((i - announce_lat_lp) % announce_gap_lp) == 0) && (k < 6);
            check_val("t2_ready", 32'(stat_ready_o), 32'(ready_tbl[i]));
            check_val("t2_v", 32'(print_stat_v_o), 32'(exp_pulse));
            check_val("t2_tag", 32'(print_stat_tag_o), exp_pulse ? 32'(8'h11 + k) : 32'd0);
            if (stat_v_i && stat_ready_o) acc++;
            tick();
        end
        stat_v_i = 1'b0;
        check_val("t2_accepted", 32'(acc), 32'd6);
        $display("T2 stream of 6 tags done, accepted=%0d", acc);

        // ---------------- T3: balanced req/resp traffic, tag mid-way ----------------
        for (int i = 0; i < 100; i++) begin
            req_v_i     = 1'b1;
            req_ready_i = 1'b1;
            resp_v_i    = 1'b1;
            resp_yumi_i = 1'b1;
            stat_v_i    = (i == 40);
            stat_tag_i  = 8'h3C;
            check_val("t3_v", 32'(print_stat_v_o), 32'(i == 40 + announce_lat_lp));
            check_val("t3_tag", 32'(print_stat_tag_o), (i == 40 + announce_lat_lp) ? 32'h3C : 32'd0);
            tick();
        end
        req_v_i     = 1'b0;
        req_ready_i = 1'b0;
        resp_v_i    = 1'b0;
        resp_yumi_i = 1'b0;
        stat_v_i    = 1'b0;
        check_val("t3_to", 32'(drain_timeout_o), 32'd0);
        $display("T3 100 cycles of simultaneous req/resp done");

`ifdef VCACHE_PRINT_STAT_DRAIN_EN
        // ---------------- T4: wait for 3 outstanding loads ----------------
        tick();
        req_v_i     = 1'b1;
        req_ready_i = 1'b1;
        tick();
        tick();
        tick();
        req_v_i     = 1'b0;
        req_ready_i = 1'b0;
        stat_v_i    = 1'b1;
        stat_tag_i  = 8'h01;
        for (int i = 1; i <= 12; i++) begin
            tick();
            stat_v_i    = 1'b0;
            resp_v_i    = (i == 4) || (i == 6) || (i == 8);
            resp_yumi_i = resp_v_i;
            check_val("t4_v", 32'(print_stat_v_o), 32'(i == 10));
            check_val("t4_tag", 32'(print_stat_tag_o), (i == 10) ? 32'h01 : 32'd0);
            check_val("t4_to", 32'(drain_timeout_o), 32'd0);
        end
        resp_v_i    = 1'b0;
        resp_yumi_i = 1'b0;
        $display("T4 drain of 3 outstanding loads done");

        // ---------------- T5: drain timeout ----------------
        tick();
        req_v_i     = 1'b1;
        req_ready_i = 1'b1;
        tick();
        req_v_i     = 1'b0;
        req_ready_i = 1'b0;
        stat_v_i    = 1'b1;
        stat_tag_i  = 8'h77;
        for (int i = 1; i <= 22; i++) begin
            tick();
            stat_v_i = 1'b0;
            check_val("t5_v", 32'(print_stat_v_o), 32'(i == 18));
            check_val("t5_tag", 32'(print_stat_tag_o), (i == 18) ? 32'h77 : 32'd0);
            check_val("t5_to", 32'(drain_timeout_o), 32'(i >= 18));
        end
        resp_v_i    = 1'b1;
        resp_yumi_i = 1'b1;
        tick();
        resp_v_i    = 1'b0;
        resp_yumi_i = 1'b0;
        check_val("t5_to_sticky", 32'(drain_timeout_o), 32'd1);
        $display("T5 drain timeout done, drain_timeout=%0d", drain_timeout_o);
`endif

        // ---------------- T6: reset while tags are queued ----------------
        tick();
        stat_v_i   = 1'b1;
        stat_tag_i = 8'hC1;
        tick();
        stat_tag_i = 8'hC2;
        tick();
        stat_v_i = 1'b0;
        repeat (announce_lat_lp - 2) tick();
        reset_i = 1'b1;
        #1;
        check_val("t6_v_in_rst", 32'(print_stat_v_o), 32'd0);
        check_val("t6_tag_in_rst", 32'(print_stat_tag_o), 32'd0);
        check_val("t6_ready_in_rst", 32'(stat_ready_o), 32'd0);
        tick();
        reset_i = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            check_val("t6_ctr", global_ctr_o, 32'(i));
            check_val("t6_v", 32'(print_stat_v_o), 32'd0);
            check_val("t6_ready", 32'(stat_ready_o), 32'd1);
            check_val("t6_to", 32'(drain_timeout_o), 32'd0);
            tick();
        end
        stat_v_i   = 1'b1;
        stat_tag_i = 8'h5E;
        for (int i = 1; i <= announce_lat_lp + 1; i++) begin
            tick();
            stat_v_i = 1'b0;
            check_val("t6_new_v", 32'(print_stat_v_o), 32'(i == announce_lat_lp));
            check_val("t6_new_tag", 32'(print_stat_tag_o), (i == announce_lat_lp) ? 32'h5E : 32'd0);
        end
        $display("T6 reset with queued tags done, ctr=%0d", global_ctr_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
